// File: rtl/decoder_pkg.sv
// Shared types and width helpers for the decoder sequencer path.
package decoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int coeff_width(input int output_width, input int scale_factor);
    return output_width + scale_factor;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/decoder_sequencer_if.sv
// Block-in / word-out stream bundle between the polynomial source, the sequencer and the sink.
interface decoder_sequencer_if #(
  parameter int POLY_SIZE    = 16,
  parameter int OUTPUT_WIDTH = 16,
  parameter int SCALE_FACTOR = 2
);
  import decoder_pkg::*;

  localparam int CW = coeff_width(OUTPUT_WIDTH, SCALE_FACTOR);
  localparam int IW = idx_width(POLY_SIZE);

  logic                    in_valid;
  logic                    in_ready;
  logic [CW*POLY_SIZE-1:0] poly_coeff;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUTPUT_WIDTH-1:0] binary_data;
  logic                    out_last;
  logic [IW-1:0]           out_index;
  logic                    sat_flag;
  logic                    block_done;

  modport master (
    output in_valid, poly_coeff, flush, out_ready,
    input  in_ready, out_valid, binary_data, out_last, out_index, sat_flag, block_done
  );

  modport slave (
    input  in_valid, poly_coeff, flush, out_ready,
    output in_ready, out_valid, binary_data, out_last, out_index, sat_flag, block_done
  );

endinterface

// File: rtl/decoder_descale.sv
// Combinational descale of one coefficient: truncating shift, or round-half-up with saturation.
module decoder_descale
  import decoder_pkg::*;
#(
  parameter int OUTPUT_WIDTH = 16,
  parameter int SCALE_FACTOR = 2,
  parameter int ROUND_EN     = 0
) (
  input  logic [coeff_width(OUTPUT_WIDTH, SCALE_FACTOR)-1:0] coeff,
  output logic [OUTPUT_WIDTH-1:0]                            word,
  output logic                                               sat
);

  localparam int CW = coeff_width(OUTPUT_WIDTH, SCALE_FACTOR);
  localparam logic [CW:0] HALF = {{CW{1'b0}}, 1'b1} << (SCALE_FACTOR - 1);

  logic [CW:0] sum_s;
  logic [CW:0] shifted_s;

  // Rounding adds half an LSB in one extra bit so the carry out is visible to saturation.
  always_comb begin
    sum_s     = {1'b0, coeff} + HALF;
    shifted_s = sum_s >> SCALE_FACTOR;
    if (ROUND_EN != 0) begin
      if (|shifted_s[CW:OUTPUT_WIDTH]) begin
        word = '1;
        sat  = 1'b1;
      end else begin
        word = shifted_s[OUTPUT_WIDTH-1:0];
        sat  = 1'b0;
      end
    end else begin
      word = coeff[CW-1:SCALE_FACTOR];
      sat  = 1'b0;
    end
  end

endmodule

// File: rtl/decoder_sequencer.sv
// Buffers one polynomial block and streams its descaled coefficients, index 0 first.
module decoder_sequencer
  import decoder_pkg::*;
#(
  parameter int POLY_SIZE    = 16,
  parameter int OUTPUT_WIDTH = 16,
  parameter int SCALE_FACTOR = 2,
  parameter int ROUND_EN     = 0
) (
  input logic                clk,
  input logic                rst_n,
  decoder_sequencer_if.slave bus
);

  localparam int CW = coeff_width(OUTPUT_WIDTH, SCALE_FACTOR);
  localparam int IW = idx_width(POLY_SIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(POLY_SIZE - 1);

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [IW-1:0]           idx_r;
  logic [IW-1:0]           idx_nxt_s;
  logic                    done_r;
  logic                    done_nxt_s;
  logic                    load_s;
  logic                    in_ready_s;
  logic                    out_valid_s;
  logic                    last_s;
  logic [CW-1:0]           coeff_s;
  logic [OUTPUT_WIDTH-1:0] word_s;
  logic                    sat_s;
  logic [CW-1:0]           coeff_buf_r [POLY_SIZE];

  assign last_s  = (idx_r == LAST_IDX);
  assign coeff_s = coeff_buf_r[idx_r];

  // Next-state logic; flush outranks both handshakes.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    done_nxt_s  = 1'b0;
    load_s      = 1'b0;
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = ~bus.flush;
        if (!bus.flush && bus.in_valid) begin
          load_s      = 1'b1;
          idx_nxt_s   = '0;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        out_valid_s = 1'b1;
        if (bus.flush) begin
          idx_nxt_s   = '0;
          state_nxt_s = IDLE;
        end else if (bus.out_ready) begin
          if (last_s) begin
            idx_nxt_s   = '0;
            done_nxt_s  = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            idx_nxt_s = idx_r + IW'(1);
          end
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      default: begin
        idx_nxt_s   = '0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= '0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Payload buffer carries no reset: it is only read after a fresh load.
  always_ff @(posedge clk) begin
    if (load_s) begin
      for (int k = 0; k < POLY_SIZE; k++) begin
        coeff_buf_r[k] <= bus.poly_coeff[k*CW +: CW];
      end
    end else begin
      for (int k = 0; k < POLY_SIZE; k++) begin
        coeff_buf_r[k] <= coeff_buf_r[k];
      end
    end
  end

  decoder_descale #(
    .OUTPUT_WIDTH (OUTPUT_WIDTH),
    .SCALE_FACTOR (SCALE_FACTOR),
    .ROUND_EN     (ROUND_EN)
  ) u_descale (
    .coeff (coeff_s),
    .word  (word_s),
    .sat   (sat_s)
  );

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_s;
  assign bus.binary_data = word_s;
  assign bus.out_last    = out_valid_s & last_s;
  assign bus.out_index   = idx_r;
  assign bus.sat_flag    = out_valid_s & sat_s;
  assign bus.block_done  = done_r;

endmodule

// File: tb/tb_decoder_sequencer.sv
// Scoreboard bench: truncating and rounding sequencers driven in lockstep against a queue model.
module tb_decoder_sequencer;

  localparam int PS = 4;
  localparam int OW = 8;
  localparam int SF = 2;
  localparam int CW = OW + SF;
  localparam int BW = CW * PS;

  typedef struct {
    int idx;
    bit last;
    int w0;
    int w1;
    bit s1;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [BW-1:0] poly;
  logic          flush;
  logic          out_ready;

  exp_t exp_q[$];
  exp_t e;
  bit   busy;
  bit   exp_done;
  bit   chk_en;
  bit   b2b;
  int   last_pop;
  int   cyc;
  int   acc_cnt;
  int   hs_cnt;
  int   n_checks;
  int   n_errors;

  decoder_sequencer_if #(.POLY_SIZE(PS), .OUTPUT_WIDTH(OW), .SCALE_FACTOR(SF)) if0 ();
  decoder_sequencer_if #(.POLY_SIZE(PS), .OUTPUT_WIDTH(OW), .SCALE_FACTOR(SF)) if1 ();

  assign if0.in_valid   = in_valid;
  assign if0.poly_coeff = poly;
  assign if0.flush      = flush;
  assign if0.out_ready  = out_ready;
  assign if1.in_valid   = in_valid;
  assign if1.poly_coeff = poly;
  assign if1.flush      = flush;
  assign if1.out_ready  = out_ready;

  decoder_sequencer #(.POLY_SIZE(PS), .OUTPUT_WIDTH(OW), .SCALE_FACTOR(SF), .ROUND_EN(0)) dut0 (
    .clk (clk), .rst_n (rst_n), .bus (if0.slave)
  );
  decoder_sequencer #(.POLY_SIZE(PS), .OUTPUT_WIDTH(OW), .SCALE_FACTOR(SF), .ROUND_EN(1)) dut1 (
    .clk (clk), .rst_n (rst_n), .bus (if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: truncate = c / 2^SF; round = (c + 2^(SF-1)) / 2^SF, clipped to 2^OW-1.
  function automatic void push_block(input logic [BW-1:0] blk);
    exp_t x;
    int   c;
    int   r;
    for (int k = 0; k < PS; k++) begin
      c      = int'(blk[k*CW +: CW]);
      r      = (c + (1 << (SF - 1))) / (1 << SF);
      x.idx  = k;
      x.last = (k == PS - 1);
      x.w0   = c / (1 << SF);
      x.w1   = (r > 255) ? 255 : r;
      x.s1   = (r > 255);
      exp_q.push_back(x);
    end
  endfunction

  // Monitor: compare what the DUTs present this cycle, then advance the model over the next edge.
  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      if (!rst_n) begin
        exp_q.delete();
        exp_done = 1'b0;
        chk("rst_in_ready0", int'(if0.in_ready), 1);
        chk("rst_in_ready1", int'(if1.in_ready), 1);
        chk("rst_out_valid0", int'(if0.out_valid), 0);
        chk("rst_out_valid1", int'(if1.out_valid), 0);
        chk("rst_block_done0", int'(if0.block_done), 0);
        chk("rst_out_index0", int'(if0.out_index), 0);
        chk("rst_out_last0", int'(if0.out_last), 0);
        chk("rst_sat1", int'(if1.sat_flag), 0);
      end else begin
        busy = (exp_q.size() != 0);
        chk("in_ready0", int'(if0.in_ready), int'(!busy && !flush));
        chk("in_ready1", int'(if1.in_ready), int'(!busy && !flush));
        chk("out_valid0", int'(if0.out_valid), int'(busy));
        chk("out_valid1", int'(if1.out_valid), int'(busy));
        chk("block_done0", int'(if0.block_done), int'(exp_done));
        chk("block_done1", int'(if1.block_done), int'(exp_done));
        if (busy) begin
          e = exp_q[0];
          chk("data_trunc", int'(if0.binary_data), e.w0);
          chk("data_round", int'(if1.binary_data), e.w1);
          chk("sat_trunc", int'(if0.sat_flag), 0);
          chk("sat_round", int'(if1.sat_flag), int'(e.s1));
          chk("index0", int'(if0.out_index), e.idx);
          chk("index1", int'(if1.out_index), e.idx);
          chk("last0", int'(if0.out_last), int'(e.last));
          chk("last1", int'(if1.out_last), int'(e.last));
        end
        exp_done = 1'b0;
        if (flush) begin
          exp_q.delete();
        end else if (busy) begin
          if (out_ready) begin
            if (b2b && e.idx == 0 && last_pop >= 0) chk("b2b_gap", cyc - last_pop, 2);
            if (e.last) begin
              exp_done = 1'b1;
              last_pop = cyc;
            end
            hs_cnt++;
            void'(exp_q.pop_front());
          end
        end else if (in_valid) begin
          push_block(poly);
          acc_cnt++;
        end
      end
    end
  end

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] b;
    int v;
    for (int k = 0; k < PS; k++) begin
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1016, 1023)) : int'($urandom_range(0, 1023));
      b[k*CW +: CW] = v[CW-1:0];
    end
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int start);
    for (int i = 0; i < 100 && acc_cnt == start; i++) step();
    chk("accept_seen", int'(acc_cnt != start), 1);
  endtask

  task automatic send_block(input logic [BW-1:0] blk);
    int start;
    start    = acc_cnt;
    poly     = blk;
    in_valid = 1'b1;
    wait_accept(start);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    poly     = rand_block();
    chk_en   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  logic [BW-1:0] blk_a;
  logic [BW-1:0] blk_b;
  bit   bp_pat [7];
  int   hs0;
  int   start;

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; poly = '0; flush = 1'b0; out_ready = 1'b1;
    chk_en = 1'b0; b2b = 1'b0; last_pop = -1;
    cyc = 0; acc_cnt = 0; hs_cnt = 0; n_checks = 0; n_errors = 0;
    step();
    do_reset();
    chk("no_capture_in_reset", acc_cnt, 0);

    blk_a = {10'h001, 10'h3FF, 10'h006, 10'h004};
    hs0 = hs_cnt;
    send_block(blk_a);
    wait_idle();
    step();
    chk("directed_handshakes", hs_cnt - hs0, 4);

    bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    hs0 = hs_cnt;
    out_ready = bp_pat[0];
    send_block(rand_block());
    for (int i = 1; i < 7; i++) begin
      out_ready = bp_pat[i];
      step();
    end
    out_ready = 1'b1;
    wait_idle();
    chk("backpressure_handshakes", hs_cnt - hs0, 4);

    send_block(rand_block());
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    blk_b = rand_block();
    blk_b[CW-1:0] = 10'h010;
    send_block(blk_b);
    wait_idle();

    flush = 1'b1; in_valid = 1'b1; poly = rand_block();
    start = acc_cnt;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_blocks_accept", acc_cnt - start, 0);
    step();

    last_pop = -1;
    b2b      = 1'b1;
    start    = acc_cnt;
    poly     = rand_block();
    in_valid = 1'b1;
    wait_accept(start);
    poly  = rand_block();
    start = acc_cnt;
    wait_accept(start);
    in_valid = 1'b0;
    wait_idle();
    b2b = 1'b0;

    send_block(rand_block());
    do_reset();

    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 2) == 0);
      poly      = rand_block();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    wait_idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
